// File: rtl/mulc_pkg.sv
// Shared sizing helpers and lane control encoding for the complex multiply/accumulate path.
package mulc_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int N_DEFAULT  = 16;

    typedef enum logic [1:0] {
        LANE_HOLD = 2'd0,
        LANE_ADD  = 2'd1,
        LANE_LOAD = 2'd2
    } lane_op_e;

    // Accumulator width that holds N products of DW bits without overflow.
    function automatic int acc_width(input int dw, input int n);
        return dw + $clog2(n);
    endfunction

    // Counter width able to represent 0..N.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mulc_acc_lane.sv
// One signed accumulator lane.
// LOAD moves (acc + din) into the output register and clears acc in the same edge.
module mulc_acc_lane
    import mulc_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = acc_width(DW_DEFAULT, N_DEFAULT)
) (
    input  logic          clk,
    input  logic          nreset,
    input  lane_op_e      op,
    input  logic [DW-1:0] din,
    output logic [AW-1:0] dout
);

    logic [AW-1:0] acc_r;
    logic [AW-1:0] dout_r;
    logic [AW-1:0] ext_s;
    logic [AW-1:0] sum_s;

    assign ext_s = {{(AW-DW){din[DW-1]}}, din};
    assign sum_s = acc_r + ext_s;
    assign dout  = dout_r;

    // Accumulator and frame-sum registers.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            acc_r  <= {AW{1'b0}};
            dout_r <= {AW{1'b0}};
        end else begin
            case (op)
                LANE_HOLD: begin
                    acc_r <= acc_r;
                end
                LANE_ADD: begin
                    acc_r <= sum_s;
                end
                LANE_LOAD: begin
                    dout_r <= sum_s;
                    acc_r  <= {AW{1'b0}};
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/mulc_acc.sv
// Complex frame accumulator: sums up to N signed complex products per frame and
// presents one full-precision sum per frame on a valid/ready output.
module mulc_acc
    import mulc_pkg::*;
#(
    parameter  int DW = DW_DEFAULT,
    parameter  int N  = N_DEFAULT,
    localparam int AW = acc_width(DW, N),
    localparam int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_re,
    output logic [AW-1:0] out_im,
    output logic [CW-1:0] out_cnt
);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] out_cnt_r;
    logic          out_valid_r;
    logic          pending_s;
    logic          stall_s;
    logic          beat_s;
    lane_op_e      op_s;

    // Only a frame-ending beat needs the output slot, so only it can stall.
    assign pending_s = (cnt_r == CW'(N - 1)) | in_last;
    assign stall_s   = out_valid_r & ~out_ready;
    assign in_ready  = ~stall_s | ~pending_s;
    assign beat_s    = in_valid & in_ready;

    assign out_valid = out_valid_r;
    assign out_cnt   = out_cnt_r;

    // Lane operation select for the accepted beat.
    always_comb begin
        op_s = LANE_HOLD;
        if (beat_s) begin
            if (pending_s) begin
                op_s = LANE_LOAD;
            end else begin
                op_s = LANE_ADD;
            end
        end else begin
            op_s = LANE_HOLD;
        end
    end

    // Beat counter and output-slot occupancy.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_r       <= {CW{1'b0}};
            out_cnt_r   <= {CW{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (op_s)
                LANE_LOAD: begin
                    out_cnt_r   <= cnt_r + CW'(1);
                    cnt_r       <= {CW{1'b0}};
                    out_valid_r <= 1'b1;
                end
                LANE_ADD: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
            endcase
        end
    end

    mulc_acc_lane #(.DW(DW), .AW(AW)) u_lane_re (
        .clk    (clk),
        .nreset (nreset),
        .op     (op_s),
        .din    (in_re),
        .dout   (out_re)
    );

    mulc_acc_lane #(.DW(DW), .AW(AW)) u_lane_im (
        .clk    (clk),
        .nreset (nreset),
        .op     (op_s),
        .din    (in_im),
        .dout   (out_im)
    );

endmodule

// File: tb/tb_mulc_acc.sv
// Scoreboard bench for mulc_acc (N=4, DW=32): directed frames plus randomised
// valid/ready gaps, with a decoupled output monitor.
module tb_mulc_acc;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int AW = 34;
    localparam int CW = 3;

    typedef struct {
        longint re;
        longint im;
        int     cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_re;
    logic [AW-1:0] out_im;
    logic [CW-1:0] out_cnt;

    int     checks = 0;
    int     passes = 0;
    bit     rand_rdy = 1'b0;
    exp_t   q[$];
    longint m_re = 0;
    longint m_im = 0;
    int     m_cnt = 0;

    mulc_acc #(.DW(DW), .N(N)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: push the expected sum when a frame-ending beat is accepted.
    task automatic model_accept(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        m_re += longint'($signed(re));
        m_im += longint'($signed(im));
        m_cnt++;
        if (m_cnt == N || last) begin
            q.push_back('{m_re, m_im, m_cnt});
            m_re = 0;
            m_im = 0;
            m_cnt = 0;
        end
    endtask

    // Present one beat; returns at posedge+1 after it is accepted.
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        bit rdy;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_re = re;
        in_im = im;
        in_last = last;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 1000) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        if (rdy) model_accept(re, im, last);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        q.delete();
        m_re = 0;
        m_im = 0;
        m_cnt = 0;
    endtask

    // Monitor: compare every accepted output beat against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (nreset && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_re", longint'($signed(out_re)), e.re);
                    chk("out_im", longint'($signed(out_im)), e.im);
                    chk("out_cnt", longint'(out_cnt), longint'(e.cnt));
                end
            end
        end
    end

    // Random downstream backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int len;
        int w;
        logic lst;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_re", longint'(out_re), 0);
        chk("rst_out_im", longint'(out_im), 0);
        chk("rst_out_cnt", longint'(out_cnt), 0);
        chk("rst_in_ready", longint'(in_ready), 1);

        // 1: basic frame, latency 1
        out_ready = 1'b1;
        send(32'sd1, 32'sd2, 1'b0);
        send(32'sd3, 32'sd4, 1'b0);
        send(32'sd5, 32'sd6, 1'b0);
        send(32'sd7, 32'sd8, 1'b0);
        chk("t1_valid", longint'(out_valid), 1);
        chk("t1_re", longint'($signed(out_re)), 16);
        chk("t1_im", longint'($signed(out_im)), 20);
        chk("t1_cnt", longint'(out_cnt), 4);
        @(posedge clk);
        #1;
        chk("t1_single_beat", longint'(out_valid), 0);

        // 2: most negative inputs, no wrap
        repeat (4) send(32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("t2_re", longint'($signed(out_re)), -64'sd8589934592);
        chk("t2_im", longint'($signed(out_im)), -64'sd8589934592);
        chk("t2_cnt", longint'(out_cnt), 4);
        @(posedge clk);
        #1;

        // 4: early end on the 2nd beat, then a fresh full frame
        send(32'sd10, -32'sd1, 1'b0);
        send(-32'sd3, 32'sd5, 1'b1);
        chk("t4_re", longint'($signed(out_re)), 7);
        chk("t4_im", longint'($signed(out_im)), 4);
        chk("t4_cnt", longint'(out_cnt), 2);
        repeat (4) send(32'sd1, 32'sd1, 1'b0);
        chk("t4_next_re", longint'($signed(out_re)), 4);
        chk("t4_next_cnt", longint'(out_cnt), 4);
        @(posedge clk);
        #1;

        // 3: backpressure across two frames
        out_ready = 1'b0;
        send(32'sd1, -32'sd1, 1'b0);
        send(32'sd2, -32'sd2, 1'b0);
        send(32'sd3, -32'sd3, 1'b0);
        send(32'sd4, -32'sd4, 1'b0);
        chk("t3_b1_ready", longint'(in_ready), 1);
        send(32'sd100, 32'sd0, 1'b0);
        chk("t3_b2_ready", longint'(in_ready), 1);
        send(32'sd200, 32'sd0, 1'b0);
        chk("t3_b3_ready", longint'(in_ready), 1);
        send(32'sd300, 32'sd0, 1'b0);
        in_valid = 1'b1;
        in_re = 32'sd400;
        in_im = 32'sd7;
        in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_ready", longint'(in_ready), 0);
            chk("t3_held_valid", longint'(out_valid), 1);
            chk("t3_held_re", longint'($signed(out_re)), 10);
            chk("t3_held_im", longint'($signed(out_im)), -10);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        model_accept(32'sd400, 32'sd7, 1'b0);
        in_valid = 1'b0;
        chk("t3_b2b_valid", longint'(out_valid), 1);
        chk("t3_b2b_re", longint'($signed(out_re)), 1000);
        chk("t3_b2b_im", longint'($signed(out_im)), 7);
        @(posedge clk);
        #1;

        // 5: reset mid-frame, then reset with a held output
        send(32'sd5, 32'sd5, 1'b0);
        send(32'sd6, 32'sd6, 1'b0);
        do_reset();
        chk("t5a_valid", longint'(out_valid), 0);
        out_ready = 1'b0;
        repeat (4) send(32'sd1, 32'sd2, 1'b0);
        send(32'sd5, 32'sd5, 1'b0);
        send(32'sd6, 32'sd6, 1'b0);
        do_reset();
        chk("t5b_valid", longint'(out_valid), 0);
        chk("t5b_re", longint'(out_re), 0);
        chk("t5b_cnt", longint'(out_cnt), 0);
        out_ready = 1'b1;
        repeat (4) send(32'sd2, 32'sd3, 1'b0);
        chk("t5_re", longint'($signed(out_re)), 8);
        chk("t5_im", longint'($signed(out_im)), 12);
        chk("t5_cnt", longint'(out_cnt), 4);
        @(posedge clk);
        #1;

        // 6: random gaps and backpressure against the model
        rand_rdy = 1'b1;
        for (int f = 0; f < 3000; f++) begin
            len = $urandom_range(1, N);
            for (int b = 0; b < len; b++) begin
                w = $urandom_range(0, 2);
                repeat (w) begin
                    @(posedge clk);
                    #1;
                end
                lst = (b == len - 1) && ((len < N) || ($urandom_range(0, 1) == 1));
                send($urandom, $urandom, lst);
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", longint'(q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
